// File: rtl/mux_n_stream_pkg.sv
// Shared types and helpers for the mux_n_stream channel multiplexer.
package mux_n_stream_pkg;

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  localparam int unsigned BeatCntW = 16;

  // LSB position of channel ch inside the flattened per-channel data bus.
  function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/mux_n_stream_oreg.sv
// Single-entry output register with valid/ready hold; data is frozen while stalled.
module mux_n_stream_oreg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;
  logic             load;

  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/mux_n_stream.sv
// NCH-channel stream mux that locks one channel for a whole packet.
// Optional beat counter enabled by MUX_N_STREAM_BEAT_CNT_EN.
module mux_n_stream
  import mux_n_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SELW-1:0]       sel,
  input  logic                  sel_load,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH-1:0]        in_last,
  output logic [NCH-1:0]        in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [SELW-1:0]       cur_sel,
  output logic                  sel_err,
  output logic [BeatCntW-1:0]   beat_cnt
);

  state_e          state_q, state_d;
  logic [SELW-1:0] cur_sel_q, cur_sel_d;
  logic            sel_err_q, sel_err_d;
  logic [31:0]     sel_ext;
  logic            locked;
  logic            oreg_ready;
  logic            accept;
  logic [WIDTH:0]  oreg_out;

  assign sel_ext = 32'(sel);
  assign locked  = (state_q == StLock);
  assign accept  = locked && in_valid[cur_sel_q] && oreg_ready;

  always_comb begin
    in_ready = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      in_ready[c] = locked && (SELW'(c) == cur_sel_q) && oreg_ready;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    sel_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_load) begin
          if (sel_ext < NCH) begin
            cur_sel_d = sel;
            state_d   = StLock;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      StLock: begin
        // Any select request while locked is rejected, even on the last beat.
        sel_err_d = sel_load;
        if (accept && in_last[cur_sel_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cur_sel_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Last flag travels alongside the data in the top bit of the output register.
  mux_n_stream_oreg #(
    .Width (WIDTH + 1)
  ) u_oreg (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (locked && in_valid[cur_sel_q]),
    .in_ready_o  (oreg_ready),
    .in_data_i   ({in_last[cur_sel_q], in_data[chan_lsb(32'(cur_sel_q), WIDTH) +: WIDTH]}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (oreg_out)
  );

  assign out_data = oreg_out[WIDTH-1:0];
  assign out_last = oreg_out[WIDTH];
  assign busy     = locked;
  assign cur_sel  = cur_sel_q;
  assign sel_err  = sel_err_q;

`ifdef MUX_N_STREAM_BEAT_CNT_EN
  logic [BeatCntW-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (state_q == StIdle && state_d == StLock) begin
      beat_cnt_d = '0;
    end else if (accept && beat_cnt_q != '1) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_n_stream.sv
// Directed self-checking bench for mux_n_stream (NCH=4 main instance, NCH=3 for illegal select).
module tb_mux_n_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          failures = 0;

  // Main instance, NCH=4
  logic [1:0]  sel;
  logic        sel_load;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_last, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_last, out_ready, busy, sel_err;
  logic [1:0]  cur_sel;
  logic [15:0] beat_cnt;

  // Second instance, NCH=3
  logic [1:0]  sel3;
  logic        sel_load3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3, out_last3, busy3, sel_err3;
  logic [1:0]  cur_sel3;
  logic [15:0] beat_cnt3;

`ifdef MUX_N_STREAM_BEAT_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  always #5 clk = ~clk;

  mux_n_stream #(.WIDTH(8), .NCH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .sel_load(sel_load), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready), .busy(busy),
    .cur_sel(cur_sel), .sel_err(sel_err), .beat_cnt(beat_cnt)
  );

  mux_n_stream #(.WIDTH(8), .NCH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .sel(sel3), .sel_load(sel_load3), .in_data(24'h0),
    .in_valid(3'b000), .in_last(3'b000), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_last(out_last3), .out_ready(1'b1), .busy(busy3),
    .cur_sel(cur_sel3), .sel_err(sel_err3), .beat_cnt(beat_cnt3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ch(input int c, input logic [7:0] d, input logic v, input logic l);
    in_data[c*8 +: 8] = d;
    in_valid[c]       = v;
    in_last[c]        = l;
  endtask

  task automatic lock(input logic [1:0] ch);
    sel      = ch;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel = '0; sel_load = 1'b0; in_data = '0; in_valid = '0; in_last = '0;
    out_ready = 1'b1; sel3 = '0; sel_load3 = 1'b0;
    tick(); tick();
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_cur_sel", 32'(cur_sel), 0);
    check_eq("rst_sel_err", 32'(sel_err), 0);
    check_eq("rst_beat_cnt", 32'(beat_cnt), 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_in_ready", 32'(in_ready), 0);

    // Illegal select on NCH=3 instance
    sel3 = 2'd3; sel_load3 = 1'b1;
    tick();
    sel_load3 = 1'b0;
    check_eq("illegal_sel_err", 32'(sel_err3), 1);
    check_eq("illegal_busy", 32'(busy3), 0);
    tick();
    check_eq("illegal_sel_err_pulse", 32'(sel_err3), 0);
    check_eq("illegal_busy_after", 32'(busy3), 0);

    // Basic lock/stream on ch1
    lock(2'd1);
    check_eq("basic_busy", 32'(busy), 1);
    check_eq("basic_cur_sel", 32'(cur_sel), 1);
    check_eq("basic_in_ready", 32'(in_ready), 32'h2);
    check_eq("basic_ov_before", 32'(out_valid), 0);
    drive_ch(1, 8'h11, 1'b1, 1'b0);
    tick();
    check_eq("basic_d0", 32'(out_data), 32'h11);
    check_eq("basic_v0", 32'(out_valid), 1);
    drive_ch(1, 8'h22, 1'b1, 1'b0);
    tick();
    check_eq("basic_d1", 32'(out_data), 32'h22);
    check_eq("basic_l1", 32'(out_last), 0);
    drive_ch(1, 8'h33, 1'b1, 1'b1);
    tick();
    check_eq("basic_d2", 32'(out_data), 32'h33);
    check_eq("basic_l2", 32'(out_last), 1);
    check_eq("basic_busy_drop", 32'(busy), 0);
    check_eq("basic_in_ready_idle", 32'(in_ready), 0);
    drive_ch(1, 8'h00, 1'b0, 1'b0);
    tick();
    check_eq("basic_drained", 32'(out_valid), 0);

    // Backpressure on ch0, with a rejected select during the stall
    lock(2'd0);
    check_eq("bp_busy", 32'(busy), 1);
    drive_ch(0, 8'hA0, 1'b1, 1'b0);
    tick();
    check_eq("bp_d0", 32'(out_data), 32'hA0);
    drive_ch(0, 8'hA1, 1'b1, 1'b0);
    out_ready = 1'b0;
    #1;
    check_eq("bp_in_ready_stall", 32'(in_ready), 0);
    sel = 2'd2; sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    check_eq("bp_stall1_data", 32'(out_data), 32'hA0);
    check_eq("bp_stall1_valid", 32'(out_valid), 1);
    check_eq("busy_sel_err", 32'(sel_err), 1);
    check_eq("busy_cur_sel", 32'(cur_sel), 0);
    tick();
    check_eq("bp_stall2_data", 32'(out_data), 32'hA0);
    check_eq("bp_stall2_ready", 32'(in_ready), 0);
    check_eq("busy_sel_err_pulse", 32'(sel_err), 0);
    tick();
    check_eq("bp_stall3_data", 32'(out_data), 32'hA0);
    out_ready = 1'b1;
    #1;
    check_eq("bp_in_ready_resume", 32'(in_ready), 32'h1);
    tick();
    check_eq("bp_d1", 32'(out_data), 32'hA1);
    drive_ch(0, 8'hA2, 1'b1, 1'b0);
    tick();
    check_eq("bp_d2", 32'(out_data), 32'hA2);
    drive_ch(0, 8'hA3, 1'b1, 1'b1);
    tick();
    check_eq("bp_d3", 32'(out_data), 32'hA3);
    check_eq("bp_last", 32'(out_last), 1);
    check_eq("bp_busy_drop", 32'(busy), 0);
    drive_ch(0, 8'h00, 1'b0, 1'b0);
    tick();
    check_eq("bp_drained", 32'(out_valid), 0);

    // Isolation: lock ch3 while ch0..2 shout 0xFF
    for (int c = 0; c < 3; c++) drive_ch(c, 8'hFF, 1'b1, 1'b1);
    #1;
    check_eq("iso_idle_ready", 32'(in_ready), 0);
    lock(2'd3);
    check_eq("iso_in_ready", 32'(in_ready), 32'h8);
    drive_ch(3, 8'h31, 1'b1, 1'b0);
    tick();
    check_eq("iso_d0", 32'(out_data), 32'h31);
    check_eq("iso_busy", 32'(busy), 1);
    check_eq("iso_in_ready2", 32'(in_ready), 32'h8);
    drive_ch(3, 8'h32, 1'b1, 1'b1);
    tick();
    check_eq("iso_d1", 32'(out_data), 32'h32);
    check_eq("iso_last", 32'(out_last), 1);
    check_eq("iso_in_ready_end", 32'(in_ready), 0);
    in_valid = '0; in_last = '0; in_data = '0;
    tick();

    // Beat counter: 5-beat packet on ch2
    lock(2'd2);
    check_eq("cnt_after_lock", 32'(beat_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      drive_ch(2, 8'(8'h50 + i), 1'b1, (i == 4));
      tick();
      check_eq("cnt_data", 32'(out_data), 32'h50 + i);
    end
    drive_ch(2, 8'h00, 1'b0, 1'b0);
    check_eq("cnt_five", 32'(beat_cnt), CntEn ? 32'd5 : 32'd0);
    tick();
    check_eq("cnt_hold_idle", 32'(beat_cnt), CntEn ? 32'd5 : 32'd0);
    lock(2'd2);
    check_eq("cnt_cleared", 32'(beat_cnt), 0);

    // Reset mid-packet
    drive_ch(2, 8'h61, 1'b1, 1'b0);
    tick();
    drive_ch(2, 8'h62, 1'b1, 1'b0);
    tick();
    check_eq("mid_pre_valid", 32'(out_valid), 1);
    check_eq("mid_pre_data", 32'(out_data), 32'h62);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 0);
    check_eq("mid_rst_cnt", 32'(beat_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_busy", 32'(busy), 0);
    check_eq("post_rst_in_ready", 32'(in_ready), 0);
    check_eq("post_rst_valid", 32'(out_valid), 0);
    in_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_n_stream.md
Name: mux_n_stream

Overview:
- Parametrised WIDTH-bit, NCH-channel stream multiplexer. It generalises the 1-bit 2:1 switch-level mux.
- Adds a clocked select lock, valid/ready handshakes and packet-boundary switching, so a channel switch can never split a packet.
- Sits between several producer streams and a single consumer. Output is registered, with latency 1.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 4, number of input channels (>=2).
- SELW, $clog2(NCH), select width. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- sel  input  SELW  channel to lock
- sel_load  input  1  request to lock channel sel
- in_data  input  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel valid
- in_last  input  NCH  per-channel end-of-packet marker
- in_ready  output  NCH  per-channel ready
- out_data  output  WIDTH  registered data
- out_valid  output  1  output beat valid
- out_last  output  1  registered last
- out_ready  input  1  consumer ready
- busy  output  1  a channel is locked
- cur_sel  output  SELW  locked channel
- sel_err  output  1  one-cycle pulse: illegal or rejected select
- beat_cnt  output  16  beats of current packet (optional feature)

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; out_valid=0; out_data=0; out_last=0; busy=0; cur_sel=0; sel_err=0; beat_cnt=0.
  - Assertion mid-packet drops the partial packet and any held output beat.
- State IDLE:
  - in_ready all 0.
  - sel_load=1 with sel<NCH: cur_sel<=sel, state<=LOCK, busy<=1 next cycle.
  - sel_load=1 with sel>=NCH: state stays IDLE, sel_err=1 for one cycle.
- State LOCK:
  - Channel cur_sel is connected; all other in_ready bits are 0.
  - in_ready[cur_sel] = !out_valid || out_ready. This gives full throughput, one beat per cycle.
  - Accept = in_valid[cur_sel] && in_ready[cur_sel]. On accept, at the next edge: out_data<=channel data, out_last<=in_last[cur_sel], out_valid<=1.
  - out_ready && out_valid without a new accept: out_valid<=0.
  - Accepted beat with in_last=1: state<=IDLE and busy<=0 at the same edge. The held output beat still drains normally.
  - sel_load in LOCK (including the cycle of the last beat): ignored; sel_err=1 for one cycle.
- Output hold: out_data, out_last and out_valid stay stable while out_valid=1 and out_ready=0 (AXI-style rule).
- in_valid on non-selected channels has no effect. Those producers must hold their data.
- Latency: accepted beat appears on out_* the following cycle.
- Unused bits: when NCH is not a power of two, sel values NCH..2^SELW-1 are illegal (sel_err).

Optional Feature:
- Macro MUX_N_STREAM_BEAT_CNT_EN.
- Defined:
  - beat_cnt clears to 0 on IDLE->LOCK.
  - beat_cnt increments on every accepted beat and saturates at 16'hFFFF.
  - beat_cnt holds its value after return to IDLE until the next lock.
- Undefined: beat_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared package mux_n_stream_pkg:
  - state enum {IDLE, LOCK}
  - BEAT_CNT_W=16 constant
  - function for the channel slice.
- One natural sub-module: mux_n_stream_oreg, the single-entry output register with valid/ready hold. It is reusable in other stream blocks.
- The channel select is a plain indexed part-select in the parent.

Test Plan:
- Reset mid-packet: lock ch2, send 2 beats, pull rst_n low while out_valid=1 -> out_valid=0, busy=0, in_ready=0 immediately (async); after release, state is IDLE.
- Basic lock/stream: sel=1, sel_load pulse; ch1 sends 0x11,0x22,0x33 (last on 0x33) with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after accept; busy drops at the edge after 0x33 is accepted.
- Backpressure: lock ch0, stream 0xA0..0xA3, hold out_ready=0 for 3 cycles after first beat -> out_data stays 0xA0, in_ready[0]=0 during the stall; no beat lost or duplicated.
- Illegal/busy select: NCH=3, sel=3 sel_load in IDLE -> sel_err pulse, busy stays 0. While ch0 is locked, sel=2 sel_load -> sel_err pulse, cur_sel stays 0.
- Isolation: lock ch3; ch0..ch2 drive in_valid=1 with 0xFF -> only ch3 data appears; in_ready[0..2]=0 throughout.
- With MUX_N_STREAM_BEAT_CNT_EN: 5-beat packet -> beat_cnt=5 after last accept; next lock -> beat_cnt=0. Without the macro, beat_cnt is always 0.
